aes_mix_columns_engine: RTL and testbench

//  Multi-cycle AES (Inverse)MixColumns engine for one 128-bit state. Per-transaction mode: forward or inverse.

---
 rtl/aes_mix_columns_engine_pkg.sv | 40 ++++
 rtl/aes_mix_columns_engine_word.sv | 28 ++
 rtl/aes_mix_columns_engine.sv | 102 ++++++++++
 tb/tb_aes_mix_columns_engine.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/aes_mix_columns_engine_pkg.sv
// Shared AES MixColumns definitions: GF(2^8) helpers built from xtime,
// datapath widths and the engine state encoding.
package aes_pkg;

  localparam int AES_W    = 128;
  localparam int COL_W    = 32;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B)
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/aes_mix_columns_engine_word.sv
// Combinational (Inv)MixColumns on one 32-bit column; row 0 is the top byte.
module aes_mix_column_word
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] word,
  input  logic             inv,
  output logic [COL_W-1:0] result
);

  logic [7:0] a [NUM_COLS];

  always_comb begin
    result = '0;
    for (int r = 0; r < NUM_COLS; r++) begin
      a[r] = word[COL_W-1-8*r -: 8];
    end
    for (int r = 0; r < NUM_COLS; r++) begin
      if (inv) begin
        result[COL_W-1-8*r -: 8] = gf_mule(a[r]) ^ gf_mulb(a[(r+1)%4]) ^
                                   gf_muld(a[(r+2)%4]) ^ gf_mul9(a[(r+3)%4]);
      end else begin
        result[COL_W-1-8*r -: 8] = gf_mul2(a[r]) ^ gf_mul3(a[(r+1)%4]) ^
                                   a[(r+2)%4] ^ a[(r+3)%4];
      end
    end
  end

endmodule

// File: rtl/aes_mix_columns_engine.sv
// Multi-cycle (Inv)MixColumns engine: transforms COLS_PER_CYCLE columns of the
// 128-bit state per clock in place, with valid/ready on both sides.
module aes_mix_columns_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter int OUT_REG        = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [AES_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AES_W-1:0] out_data,
  output logic             busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("aes_mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(NUM_COLS - COLS_PER_CYCLE);

  state_t           state, state_nxt;
  logic [1:0]       cnt;
  logic             inv_mode;
  logic             drain;
  logic [AES_W-1:0] work;
  logic             accept;
  logic             last_grp;

  logic [COL_W-1:0] col_word [COLS_PER_CYCLE];
  logic [COL_W-1:0] col_res  [COLS_PER_CYCLE];

  assign accept    = in_valid && in_ready;
  assign last_grp  = (cnt == LAST);
  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign col_word[k] = work[AES_W-1-COL_W*(int'(cnt)+k) -: COL_W];
    aes_mix_column_word u_word (
      .word   (col_word[k]),
      .inv    (inv_mode),
      .result (col_res[k])
    );
  end

  // drain marks the extra cycle that copies the finished state into the output register
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (drain || (last_grp && OUT_REG == 0)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      inv_mode <= 1'b0;
      drain    <= 1'b0;
      work     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        work     <= in_data;
        inv_mode <= in_inv;
        cnt      <= '0;
        drain    <= 1'b0;
      end else if (state == CALC && !drain) begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          work[AES_W-1-COL_W*(int'(cnt)+k) -: COL_W] <= col_res[k];
        end
        if (last_grp) drain <= (OUT_REG != 0);
        else          cnt   <= cnt + STEP;
      end else if (state == CALC) begin
        drain <= 1'b0;
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [AES_W-1:0] out_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      out_q <= '0;
      else if (state == CALC && drain) out_q <= work;
    end
    assign out_data = out_q;
  end else begin : g_noreg
    assign out_data = (state == DONE) ? work : '0;
  end

endmodule

// File: tb/tb_aes_mix_columns_engine.sv
// Directed and round-trip bench for aes_mix_columns_engine over all six
// COLS_PER_CYCLE x OUT_REG combinations, sharing clock, reset and input data.
module tb_aes_mix_columns_engine;

  localparam int N = 6;
  localparam int CPC_TAB  [N] = '{1, 1, 2, 2, 4, 4};
  localparam int OREG_TAB [N] = '{1, 0, 1, 0, 1, 0};
  localparam int LAT_TAB  [N] = '{5, 4, 3, 2, 2, 1};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_inv = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_valid_a  [N];
  logic         in_ready_a  [N];
  logic         out_valid_a [N];
  logic         out_ready_a [N];
  logic [127:0] out_data_a  [N];
  logic         busy_a      [N];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    aes_mix_columns_engine #(
      .COLS_PER_CYCLE (CPC_TAB[g]),
      .OUT_REG        (OREG_TAB[g])
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .in_inv    (in_inv),
      .in_data   (in_data),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .out_data  (out_data_a[g]),
      .busy      (busy_a[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive one state into instance k; in_inv is flipped right after accept.
  task automatic send(input int k, input logic [127:0] d, input logic inv);
    check($sformatf("in_ready_before_send[%0d]", k), 128'(in_ready_a[k]), 128'd1);
    in_data = d;
    in_inv = inv;
    in_valid_a[k] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_a[k] = 1'b0;
    in_inv = ~inv;
  endtask

  task automatic wait_out(input int k, output logic [127:0] res);
    int n;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid_a[k]) break;
    end
    check($sformatf("out_valid_seen[%0d]", k), 128'(out_valid_a[k]), 128'd1);
    check($sformatf("latency[%0d]", k), 128'(n), 128'(LAT_TAB[k]));
    res = out_data_a[k];
  endtask

  task automatic consume(input int k);
    out_ready_a[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_a[k] = 1'b0;
    check($sformatf("out_valid_dropped[%0d]", k), 128'(out_valid_a[k]), 128'd0);
  endtask

  task automatic xact(input int k, input logic [127:0] d, input logic inv, output logic [127:0] res);
    send(k, d, inv);
    wait_out(k, res);
    consume(k);
  endtask

  localparam logic [127:0] S1_IN  = 128'hdb135345_00000000_00000000_00000000;
  localparam logic [127:0] S1_OUT = 128'h8e4da1bc_00000000_00000000_00000000;
  localparam logic [127:0] S2_IN  = 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5;
  localparam logic [127:0] S2_OUT = 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6;

  initial begin
    logic [127:0] res, fwd, d, held;
    for (int k = 0; k < N; k++) begin
      in_valid_a[k] = 1'b0;
      out_ready_a[k] = 1'b0;
    end

    // reset state
    #12;
    check("rst_in_ready", 128'(in_ready_a[0]), 128'd1);
    check("rst_out_valid", 128'(out_valid_a[0]), 128'd0);
    check("rst_out_data", out_data_a[0], 128'd0);
    check("rst_busy", 128'(busy_a[0]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // out_ready while idle is ignored
    out_ready_a[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_a[0] = 1'b0;
    check("idle_out_ready_valid", 128'(out_valid_a[0]), 128'd0);
    check("idle_out_ready_busy", 128'(busy_a[0]), 128'd0);

    // directed vectors on every configuration
    for (int k = 0; k < N; k++) begin
      xact(k, S1_IN, 1'b0, res);
      check($sformatf("fwd_s1[%0d]", k), res, S1_OUT);
      xact(k, S2_IN, 1'b0, res);
      check($sformatf("fwd_s2[%0d]", k), res, S2_OUT);
      xact(k, S1_OUT, 1'b1, res);
      check($sformatf("inv_s1[%0d]", k), res, S1_IN);
      xact(k, S2_OUT, 1'b1, res);
      check($sformatf("inv_s2[%0d]", k), res, S2_IN);
    end

    // backpressure, then accept a new state in the same cycle as the release
    send(0, S2_IN, 1'b0);
    wait_out(0, held);
    check("bp_first_result", held, S2_OUT);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 128'(out_valid_a[0]), 128'd1);
      check("bp_out_data", out_data_a[0], held);
      check("bp_in_ready", 128'(in_ready_a[0]), 128'd0);
    end
    out_ready_a[0] = 1'b1;
    in_valid_a[0] = 1'b1;
    in_data = S2_OUT;
    in_inv = 1'b1;
    #1;
    check("bp_release_in_ready", 128'(in_ready_a[0]), 128'd1);
    @(posedge clk);
    #1;
    out_ready_a[0] = 1'b0;
    in_valid_a[0] = 1'b0;
    in_inv = 1'b0;
    check("bp_back_to_back_valid", 128'(out_valid_a[0]), 128'd0);
    check("bp_back_to_back_busy", 128'(busy_a[0]), 128'd1);
    wait_out(0, res);
    check("bp_second_result", res, S2_IN);
    consume(0);

    // asynchronous reset during the second compute cycle
    send(0, S2_IN, 1'b0);
    @(posedge clk);
    #1;
    check("mid_calc_busy", 128'(busy_a[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 128'(out_valid_a[0]), 128'd0);
    check("abort_busy", 128'(busy_a[0]), 128'd0);
    check("abort_in_ready", 128'(in_ready_a[0]), 128'd1);
    check("abort_out_data", out_data_a[0], 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    xact(0, S1_IN, 1'b0, res);
    check("after_abort_fwd", res, S1_OUT);

    // random forward/inverse round trips across all configurations
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 167; i++) begin
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        xact(k, d, 1'b0, fwd);
        xact(k, fwd, 1'b1, res);
        check($sformatf("round_trip[%0d]", k), res, d);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
